// File: rtl/load_store_unit.sv
// load_store_unit
//   Accepts one RV32I load/store per req handshake, validates funct3,
//   alignment and address range, then performs a full-line read (loads) or
//   a read-modify-write of the 64-bit line (stores). Memory is always
//   accessed as a whole line, so unaddressed bytes are written back as read.
// Ports:
//   clk, aresetn             clock, async active-low reset
//   req_valid/ready          request handshake (ready only in IDLE)
//   req_we/funct3/addr/wdata request payload
//   rsp_valid/ready          response handshake
//   rsp_rdata/error/cause    response payload
//   mem_addr                 line-aligned address (read and write port)
//   mem_funct3               constant full-line access code
//   mem_rd_data              asynchronous line read data
//   mem_wr_data/mem_wr_en    merged line and one-cycle write strobe
module load_store_unit #(
  parameter int MEM_WIDTH = 15
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_error,
  output logic [1:0]           rsp_cause,
  output logic [MEM_WIDTH-1:0] mem_addr,
  output logic [2:0]           mem_funct3,
  input  logic [63:0]          mem_rd_data,
  output logic [63:0]          mem_wr_data,
  output logic                 mem_wr_en
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [2:0]           f3_q, f3_d;
  logic [2:0]           off_q, off_d;      // byte offset within the line
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [1:0]           cause_q, cause_d;
  logic [MEM_WIDTH-1:0] maddr_q, maddr_d;
  logic [63:0]          wrdata_q, wrdata_d;
  logic                 wren_q, wren_d;

  // acceptance checks on the live request
  logic illegal, misal, fault;
  always_comb begin
    if (req_we) illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else        illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    fault = (req_addr >> MEM_WIDTH) != 32'd0;
  end

  // load lane extraction
  logic [31:0] sh, ld_val;
  assign sh = 32'(mem_rd_data >> {off_q, 3'b000});
  always_comb begin
    case (f3_q)
      3'b000:  ld_val = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_val = {{16{sh[15]}}, sh[15:0]};
      3'b010:  ld_val = sh;
      3'b100:  ld_val = {24'd0, sh[7:0]};
      3'b101:  ld_val = {16'd0, sh[15:0]};
      default: ld_val = 32'd0;
    endcase
  end

  // store merge: byte mask of 1/2/4 lanes starting at off_q
  logic [7:0]  szm, bmask;
  logic [63:0] wmask, wshift, merged;
  always_comb begin
    case (f3_q[1:0])
      2'b00:   szm = 8'h01;
      2'b01:   szm = 8'h03;
      default: szm = 8'h0F;
    endcase
    bmask  = szm << off_q;
    wshift = {32'd0, wdata_q} << {off_q, 3'b000};
    for (int i = 0; i < 8; i++) wmask[8*i +: 8] = {8{bmask[i]}};
    merged = (mem_rd_data & ~wmask) | (wshift & wmask);
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cause_d  = cause_q;
    maddr_d  = maddr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        off_d   = req_addr[2:0];
        wdata_d = req_wdata;
        rdata_d = 32'd0;
        err_d   = 1'b1;
        state_d = RESP;
        if      (illegal) cause_d = 2'b11;
        else if (misal)   cause_d = 2'b01;
        else if (fault)   cause_d = 2'b10;
        else begin
          err_d   = 1'b0;
          cause_d = 2'b00;
          maddr_d = {req_addr[MEM_WIDTH-1:3], 3'b000};
          state_d = READ;
        end
      end
      READ: begin
        if (we_q) begin
          wrdata_d = merged;
          wren_d   = 1'b1;
          state_d  = WRITE;
        end else begin
          rdata_d = ld_val;
          state_d = RESP;
        end
      end
      WRITE: begin
        rdata_d = 32'd0;
        state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      off_q    <= 3'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      cause_q  <= 2'd0;
      maddr_q  <= '0;
      wrdata_q <= 64'd0;
      wren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cause_q  <= cause_d;
      maddr_q  <= maddr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = err_q;
  assign rsp_cause   = cause_q;
  assign mem_addr    = maddr_q;
  assign mem_funct3  = 3'b011;
  assign mem_wr_data = wrdata_q;
  assign mem_wr_en   = wren_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 0, aresetn = 0;
  logic        req_valid = 0, req_ready, req_we = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, rsp_ready = 1;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [1:0]  rsp_cause;
  logic [14:0] mem_addr;
  logic [2:0]  mem_funct3;
  logic [63:0] mem_rd_data, mem_wr_data;
  logic        mem_wr_en;

  int pass = 0, total = 0, wr_cnt = 0, cyc = 0;
  logic [63:0] mem [4096];

  load_store_unit #(.MEM_WIDTH(15)) dut (
    .clk(clk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_cause(rsp_cause), .mem_addr(mem_addr),
    .mem_funct3(mem_funct3), .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en));

  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr[14:3]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) begin
      mem[mem_addr[14:3]] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // present one request for a single accepting edge; returns in cycle 1 (+1ns)
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic test_reset;
    aresetn = 0;
    repeat (2) @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b exp 1", req_ready); else pass++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); else pass++;
    total++; if ({rsp_rdata, rsp_error, rsp_cause} !== 35'd0) $display("FAIL rst_rsp got %h/%b/%b exp 0", rsp_rdata, rsp_error, rsp_cause); else pass++;
    total++; if ({mem_addr, mem_wr_en, mem_wr_data} !== 80'd0) $display("FAIL rst_mem got %h/%b/%h exp 0", mem_addr, mem_wr_en, mem_wr_data); else pass++;
    total++; if (mem_funct3 !== 3'b011) $display("FAIL mem_funct3 got %b exp 011", mem_funct3); else pass++;
    aresetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads;
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] ad  [6] = '{32'h47, 32'h47, 32'h46, 32'h46, 32'h44, 32'h40};
    logic [31:0] exp [6] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8877, 32'h0000_8877, 32'h8877_6655, 32'h0000_0011};
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      send(1'b0, f3[i], ad[i], 32'h0);
      total++; if (rsp_valid !== 1'b0) $display("FAIL load%0d_c1_valid got %b exp 0", i, rsp_valid); else pass++;
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== exp[i])
        $display("FAIL load%0d_c2 got v=%b e=%b d=%h exp v=1 e=0 d=%h", i, rsp_valid, rsp_error, rsp_rdata, exp[i]); else pass++;
      @(posedge clk); #1;
      total++; if (req_ready !== 1'b1) $display("FAIL load%0d_ready got %b exp 1", i, req_ready); else pass++;
    end
  endtask

  task automatic test_store;
    int w0;
    w0 = wr_cnt;
    rsp_ready = 1;
    send(1'b1, 3'b001, 32'h42, 32'h0000_BEEF);
    total++; if (mem_wr_en !== 1'b0 || rsp_valid !== 1'b0 || mem_addr !== 15'h40)
      $display("FAIL sh_c1 got we=%b v=%b a=%h exp we=0 v=0 a=0040", mem_wr_en, rsp_valid, mem_addr); else pass++;
    @(posedge clk); #1;
    total++; if (mem_wr_en !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL sh_c2_ctl got we=%b v=%b exp we=1 v=0", mem_wr_en, rsp_valid); else pass++;
    total++; if (mem_wr_data !== 64'h8877_6655_BEEF_2211) $display("FAIL sh_wdata got %h exp 88776655beef2211", mem_wr_data); else pass++;
    @(posedge clk); #1;
    total++; if (mem_wr_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_error !== 1'b0)
      $display("FAIL sh_c3 got we=%b v=%b d=%h e=%b exp we=0 v=1 d=0 e=0", mem_wr_en, rsp_valid, rsp_rdata, rsp_error); else pass++;
    total++; if (wr_cnt - w0 !== 1) $display("FAIL sh_pulses got %0d exp 1", wr_cnt - w0); else pass++;
    @(posedge clk); #1;
    send(1'b0, 3'b010, 32'h40, 32'h0);
    @(posedge clk); #1;
    total++; if (rsp_rdata !== 32'hBEEF_2211) $display("FAIL sh_readback got %h exp beef2211", rsp_rdata); else pass++;
    @(posedge clk); #1;
    send(1'b1, 3'b010, 32'h44, 32'h1234_5678);
    repeat (3) @(posedge clk); #1;
    total++; if (mem[8] !== 64'h1234_5678_BEEF_2211) $display("FAIL sw_line got %h exp 12345678beef2211", mem[8]); else pass++;
  endtask

  task automatic test_errors;
    logic        we [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [5] = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b001};
    logic [31:0] ad [5] = '{32'h41, 32'h0001_0000, 32'h40, 32'h41, 32'h43};
    logic [1:0]  ca [5] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01};
    int w0;
    logic [14:0] a0;
    rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      w0 = wr_cnt; a0 = mem_addr;
      send(we[i], f3[i], ad[i], 32'hFFFF_FFFF);
      total++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_cause !== ca[i] || rsp_rdata !== 32'd0)
        $display("FAIL err%0d got v=%b e=%b c=%b d=%h exp v=1 e=1 c=%b d=0", i, rsp_valid, rsp_error, rsp_cause, rsp_rdata, ca[i]); else pass++;
      @(posedge clk); #1;
      total++; if (wr_cnt !== w0 || mem_addr !== a0) $display("FAIL err%0d_mem got wr=%0d a=%h exp wr=%0d a=%h", i, wr_cnt, mem_addr, w0, a0); else pass++;
    end
  endtask

  task automatic test_backpressure;
    rsp_ready = 0;
    send(1'b0, 3'b010, 32'h40, 32'h0);
    @(posedge clk); #1;
    // a competing request is presented throughout the stall
    req_valid = 1; req_we = 0; req_funct3 = 3'b000; req_addr = 32'h41;
    for (int i = 0; i < 5; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBEEF_2211 || req_ready !== 1'b0)
        $display("FAIL bp%0d got v=%b d=%h rdy=%b exp v=1 d=beef2211 rdy=0", i, rsp_valid, rsp_rdata, req_ready); else pass++;
      @(posedge clk); #1;
    end
    req_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", req_ready, rsp_valid); else pass++;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) $display("FAIL bp_not_accepted got rdy=%b exp 1", req_ready); else pass++;
  endtask

  task automatic test_back_to_back;
    int t [3];
    int n, w0;
    for (int k = 0; k < 2; k++) begin
      n = 0; w0 = wr_cnt; rsp_ready = 1;
      req_valid = 1; req_we = (k == 1); req_funct3 = 3'b010;
      req_addr = (k == 1) ? 32'h48 : 32'h40; req_wdata = 32'hCAFE_F00D;
      for (int i = 0; i < 30 && n < 3; i++) begin
        @(posedge clk); #1;
        if (rsp_valid) begin t[n] = cyc; n++; end
      end
      req_valid = 0;
      @(posedge clk); #1;
      total++; if (n !== 3) $display("FAIL b2b%0d_count got %0d exp 3", k, n);
      else if (t[1] - t[0] !== 3 + k || t[2] - t[1] !== 3 + k)
        $display("FAIL b2b%0d_period got %0d,%0d exp %0d", k, t[1] - t[0], t[2] - t[1], 3 + k);
      else pass++;
      if (k == 1) begin
        total++; if (wr_cnt - w0 !== 3) $display("FAIL b2b_writes got %0d exp 3", wr_cnt - w0); else pass++;
        total++; if (mem[9] !== 64'h0000_0000_CAFE_F00D) $display("FAIL b2b_line got %h exp 00000000cafef00d", mem[9]); else pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    w0 = wr_cnt;
    send(1'b1, 3'b010, 32'h50, 32'hDEAD_BEEF);
    aresetn = 0; #2;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_wr_en !== 1'b0 || mem_addr !== 15'd0 || mem_wr_data !== 64'd0)
      $display("FAIL rstmid_outs got rdy=%b v=%b we=%b a=%h wd=%h exp 1/0/0/0/0", req_ready, rsp_valid, mem_wr_en, mem_addr, mem_wr_data); else pass++;
    #3 aresetn = 1;
    repeat (4) @(posedge clk); #1;
    total++; if (wr_cnt !== w0 || mem[10] !== 64'd0) $display("FAIL rstmid_write got wr=%0d line=%h exp wr=%0d line=0", wr_cnt, mem[10], w0); else pass++;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rstmid_idle got rdy=%b v=%b exp 1/0", req_ready, rsp_valid); else pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 64'd0;
    mem[8] = 64'h8877_6655_4433_2211;
    test_reset;
    test_loads;
    test_store;
    test_errors;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
